image_window_ctrl: RTL and testbench

Streaming 3x3 window generator sitting directly upstream of the convolution datapath inside the image-processing top. It accepts one fixed-point pixel per cycle into four rotating line buffers. Once three full lines are buffered it emits one 3x3 window per cycle for every column of the middle line. Each time a line is retired it pulses an interrupt so the host can push the next line.

---
 rtl/image_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_image_window_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_window_ctrl.sv
// Streaming 3x3 window generator over four rotating line buffers.
// Build option: define WINDOW_ZERO_PAD_EN to zero-pad edge columns; otherwise edge pixels are replicated.
module image_window_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int LINE_WIDTH = 512
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,
  input  logic                    i_pixel_valid,
  input  logic [DATA_WIDTH-1:0]   i_pixel_data,
  output logic                    o_pixel_ready,
  output logic                    o_window_valid,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_intr,
  output logic                    o_overflow
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int NW = $clog2(4*LINE_WIDTH) + 1;

  localparam logic [NW-1:0] COUNT_FULL  = NW'(4*LINE_WIDTH);
  localparam logic [NW-1:0] COUNT_THREE = NW'(3*LINE_WIDTH);
  localparam logic [NW-1:0] COUNT_LINE  = NW'(LINE_WIDTH);
  localparam logic [CW-1:0] LAST_COL    = CW'(LINE_WIDTH-1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_wr_line;
  logic [CW-1:0]           r_wr_col;
  logic [1:0]              r_rd_line;
  logic [CW-1:0]           r_rd_col;
  logic [NW-1:0]           r_count;
  logic [9*DATA_WIDTH-1:0] r_window;
  logic                    r_window_valid;
  logic                    r_intr;
  logic                    r_overflow;

  logic [DATA_WIDTH-1:0]   r_mem [4][LINE_WIDTH];

  logic                    w_accept;
  logic                    w_drop;
  logic                    w_retire;
  logic                    w_edge_l;
  logic                    w_edge_r;
  logic [CW-1:0]           w_col_l;
  logic [CW-1:0]           w_col_r;
  logic [9*DATA_WIDTH-1:0] w_window;

  assign o_pixel_ready  = (r_count < COUNT_FULL);
  assign w_accept       = i_pixel_valid && o_pixel_ready;
  assign w_drop         = i_pixel_valid && !o_pixel_ready;
  assign w_retire       = (r_state == READ) && (r_rd_col == LAST_COL);

  assign o_window_valid = r_window_valid;
  assign o_window       = r_window;
  assign o_intr         = r_intr;
  assign o_overflow     = r_overflow;

  // Line storage is never reset; contents are only observed after being rewritten.
  always_ff @(posedge axi_clk) begin
    if (w_accept) begin
      r_mem[r_wr_line][r_wr_col] <= i_pixel_data;
    end
  end

  assign w_edge_l = (r_rd_col == '0);
  assign w_edge_r = (r_rd_col == LAST_COL);

`ifdef WINDOW_ZERO_PAD_EN
  assign w_col_l = r_rd_col - CW'(1);
  assign w_col_r = r_rd_col + CW'(1);
`else
  assign w_col_l = w_edge_l ? '0       : r_rd_col - CW'(1);
  assign w_col_r = w_edge_r ? LAST_COL : r_rd_col + CW'(1);
`endif

  // Rows are the three oldest buffered lines starting at the read line.
  always_comb begin
    w_window = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      w_window[DATA_WIDTH*(3*r)   +: DATA_WIDTH] = r_mem[r_rd_line + 2'(r)][w_col_l];
      w_window[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = r_mem[r_rd_line + 2'(r)][r_rd_col];
      w_window[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = r_mem[r_rd_line + 2'(r)][w_col_r];
`ifdef WINDOW_ZERO_PAD_EN
      if (w_edge_l) begin
        w_window[DATA_WIDTH*(3*r) +: DATA_WIDTH] = '0;
      end
      if (w_edge_r) begin
        w_window[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = '0;
      end
`endif
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state        <= IDLE;
      r_wr_line      <= '0;
      r_wr_col       <= '0;
      r_rd_line      <= '0;
      r_rd_col       <= '0;
      r_count        <= '0;
      r_window       <= '0;
      r_window_valid <= 1'b0;
      r_intr         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_wr_col == LAST_COL) begin
          r_wr_col  <= '0;
          r_wr_line <= r_wr_line + 2'd1;
        end else begin
          r_wr_col  <= r_wr_col + CW'(1);
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // Accept and retire on the same edge apply as one net update.
      r_count <= r_count + NW'(w_accept) - (w_retire ? COUNT_LINE : '0);

      r_intr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_window_valid <= 1'b0;
          if (r_count >= COUNT_THREE) begin
            r_state <= READ;
          end
        end
        READ: begin
          r_window       <= w_window;
          r_window_valid <= 1'b1;
          if (w_retire) begin
            r_rd_col  <= '0;
            r_rd_line <= r_rd_line + 2'd1;
            r_intr    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_rd_col  <= r_rd_col + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Scoreboard bench for image_window_ctrl: reference windows are computed from the
// accepted pixel stream as whole image lines and checked by an independent monitor.
module tb_image_window_ctrl;
  localparam int DW = 12;
  localparam int LW = 8;

  typedef struct {
    logic [9*DW-1:0] win;
    bit              intr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            vld = 1'b0;
  logic [DW-1:0]   dat = '0;
  logic            rdy;
  logic            wv;
  logic [9*DW-1:0] win;
  logic            intr;
  logic            ovf;

  always #5 clk = ~clk;

  image_window_ctrl #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW)
  ) dut (
    .axi_clk        (clk),
    .axi_reset_n    (rst_n),
    .i_pixel_valid  (vld),
    .i_pixel_data   (dat),
    .o_pixel_ready  (rdy),
    .o_window_valid (wv),
    .o_window       (win),
    .o_intr         (intr),
    .o_overflow     (ovf)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] img [8][LW];
  int            m_count = 0;
  int            m_acc = 0;
  int            m_next = 0;
  bit            m_ovf = 1'b0;
  bit            seen_intr = 1'b0;
  int            vcnt = 0;

  task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [9*DW-1:0] w;
    w = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return w;
  endfunction

  // Windows for image line n, whose lower neighbours n+1 and n+2 are now complete.
  task automatic push_line(input int n);
    exp_t e;
    int   col;
    for (int j = 0; j < LW; j++) begin
      e.win  = '0;
      e.intr = (j == LW-1);
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          col = j - 1 + c;
`ifdef WINDOW_ZERO_PAD_EN
          if (col >= 0 && col < LW) e.win[DW*(3*r+c) +: DW] = img[(n+r)%8][col];
`else
          if (col < 0) col = 0;
          if (col >= LW) col = LW-1;
          e.win[DW*(3*r+c) +: DW] = img[(n+r)%8][col];
`endif
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d);
    bit acc;
    vld = v;
    dat = d;
    acc = v && (m_count < 4*LW);
    @(posedge clk);
    #1;
    seen_intr = 1'b0;
    if (v && !acc) m_ovf = 1'b1;
    if (acc) begin
      img[(m_acc/LW)%8][m_acc%LW] = d;
      m_acc++;
      m_count++;
      if (m_acc % LW == 0 && m_acc / LW == m_next + 3) begin
        push_line(m_next);
        m_next++;
      end
    end
    if (intr) begin
      m_count -= LW;
      seen_intr = 1'b1;
    end
    if (wv) vcnt++;
    check("ready", rdy, m_count < 4*LW);
    vld = 1'b0;
  endtask

  task automatic wait_intr(input string name);
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, '0);
      if (seen_intr) break;
    end
    check({"intr_", name}, seen_intr, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_acc   = 0;
    m_next  = 0;
    m_ovf   = 1'b0;
    vcnt    = 0;
    #1;
    check("rst_valid", wv, 1'b0);
    check("rst_intr", intr, 1'b0);
    check("rst_overflow", ovf, 1'b0);
    check("rst_ready", rdy, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (wv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window actual=%0h required=none", win);
        end else begin
          e = exp_q.pop_front();
          check("window", win, e.win);
          check("window_intr", intr, e.intr);
        end
      end else begin
        check("intr_without_window", intr, 1'b0);
      end
      check("overflow", ovf, m_ovf);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [9*DW-1:0] first_exp;
    logic [9*DW-1:0] last_exp;
`ifdef WINDOW_ZERO_PAD_EN
    first_exp = pack9(0, 0, 1, 0, 16, 17, 0, 32, 33);
    last_exp  = pack9(6, 7, 0, 22, 23, 0, 38, 39, 0);
`else
    first_exp = pack9(0, 0, 1, 16, 16, 17, 32, 32, 33);
    last_exp  = pack9(6, 7, 7, 22, 23, 23, 38, 39, 39);
`endif

    // Full frame: 8 image lines plus 2 zero lines, one line per interrupt.
    do_reset();
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LW; c++) drive(1'b1, DW'(16*l + c));
    check("valid_at_E0", wv, 1'b0);
    drive(1'b0, '0);
    check("valid_at_E1", wv, 1'b0);
    drive(1'b0, '0);
    check("valid_at_E2", wv, 1'b1);
    check("first_window", win, first_exp);
    wait_intr("line0");
    check("last_window", win, last_exp);
    for (int l = 3; l < 10; l++) begin
      for (int c = 0; c < LW; c++) drive(1'b1, (l < 8) ? DW'(16*l + c) : '0);
      wait_intr("frame");
    end
    check("frame_windows", vcnt, 64);

    // Accept on the retiring edge: count 25 -> 18, then idle until 24.
    do_reset();
    for (int i = 0; i < 25; i++) drive(1'b1, DW'($urandom));
    for (int k = 0; k < 40 && vcnt < 7; k++) drive(1'b0, '0);
    drive(1'b1, DW'($urandom));
    check("retire_with_accept", seen_intr, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0);
      check("idle_below_three_lines", wv, 1'b0);
    end
    drive(1'b1, DW'($urandom));
    drive(1'b0, '0);
    drive(1'b0, '0);
    check("resume_valid", wv, 1'b1);
    wait_intr("resume");

    // Backpressure: 32 back-to-back pixels fill all buffers, the 33rd is dropped.
    do_reset();
    for (int i = 0; i < 32; i++) drive(1'b1, DW'($urandom));
    check("full_not_ready", rdy, 1'b0);
    drive(1'b1, 12'hABC);
    check("overflow_set", ovf, 1'b1);
    for (int i = 0; i < LW; i++) drive(1'b1, DW'($urandom));
    wait_intr("bp1");
    wait_intr("bp2");

    // Reset while windows are streaming.
    for (int i = 0; i < LW; i++) drive(1'b1, DW'($urandom));
    for (int k = 0; k < 20 && !wv; k++) drive(1'b0, '0);
    check("mid_read_valid", wv, 1'b1);
    do_reset();
    for (int i = 0; i < 3*LW-1; i++) drive(1'b1, DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0);
      check("no_window_after_reset", wv, 1'b0);
    end
    drive(1'b1, DW'($urandom));
    drive(1'b0, '0);
    drive(1'b0, '0);
    check("valid_after_reset", wv, 1'b1);
    wait_intr("post_reset");

    // Random traffic including overflow attempts.
    do_reset();
    for (int i = 0; i < 1500; i++) drive($urandom_range(0, 99) < 70, DW'($urandom));
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) drive(1'b0, '0);
    check("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
